timer_run_controller: RTL and testbench

- Sequencing FSM for the MM:SS countdown timer: four cascaded BCD down-count digits.
- Collects keypad digits into a 4-digit BCD preset.
- Issues the one-cycle parallel load to the counter chain, then gates the chain's active-low count enable with the 1 Hz tick.
- Handles pause/resume (stop button or door), completion and the done indication; the heater output sits alongside it.

---
 rtl/timer_ctrl_pkg.sv | 16 +
 rtl/bcd_preset_shift.sv | 44 ++++
 rtl/timer_run_controller.sv | 138 +++++++++++++
 tb/tb_timer_run_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared constants for the MM:SS countdown timer controller.
//   DIGIT_W  : width of one BCD digit
//   BCD_MAX  : largest legal BCD digit value
//   S_*      : FSM state encodings, also exported on state_o
package timer_ctrl_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/bcd_preset_shift.sv
// Keypad preset register: collects BCD digits shifting in from the right.
//   clk      : system clock
//   rst      : synchronous active-low reset, clears the preset
//   shift_en : request to enter digit (already gated by the FSM)
//   digit    : candidate keypad value; values above 9 are dropped here
//   clear    : zero the preset (has priority over shift_en)
//   preset   : DIGITS BCD digits, digit 0 in bits [3:0]
//   nonzero  : preset holds a non-zero time
module bcd_preset_shift
  import timer_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      shift_en,
  input  logic [DIGIT_W-1:0]        digit,
  input  logic                      clear,
  output logic [DIGIT_W*DIGITS-1:0] preset,
  output logic                      nonzero
);

  localparam int W = DIGIT_W * DIGITS;

  logic digit_ok;

  assign digit_ok = (digit <= BCD_MAX);

  // NOTE: reset is sampled on the clock edge only, so it sits inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      preset <= '0;
    end else if (clear) begin
      preset <= '0;
    end else if (shift_en && digit_ok) begin
      // Top digit falls off, new digit enters at the seconds-units position.
      preset <= {preset[W-DIGIT_W-1:0], digit};
    end
  end

  assign nonzero = |preset;

endmodule

// File: rtl/timer_run_controller.sv
// Sequencing FSM for the MM:SS countdown timer.
//   clk, rst    : system clock, synchronous active-low reset
//   tick        : 1 Hz one-cycle strobe
//   key_valid   : keypad strobe, key_data holds the digit
//   start, stop : one-cycle button strobes
//   door_open   : level, high while the door is open
//   timer_zero  : counter chain reads all zeros
//   load        : one-cycle parallel load to the counter chain
//   load_data   : BCD preset, digit 0 in bits [3:0]
//   enablen     : active-low count enable, low only on decrement cycles
//   heater      : high in RUN
//   done        : high in DONE
//   state_o     : current FSM state
module timer_run_controller
  import timer_ctrl_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DONE_TICKS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      key_valid,
  input  logic [DIGIT_W-1:0]        key_data,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      door_open,
  input  logic                      timer_zero,
  output logic                      load,
  output logic [DIGIT_W*DIGITS-1:0] load_data,
  output logic                      enablen,
  output logic                      heater,
  output logic                      done,
  output logic [2:0]                state_o
);

  localparam int CNT_W = $clog2(DONE_TICKS + 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DONE_TICKS - 1);

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] done_cnt, done_cnt_nx;
  logic             preset_clear;
  logic             key_shift;
  logic             preset_nz;

  bcd_preset_shift #(.DIGITS(DIGITS)) u_preset (
    .clk      (clk),
    .rst      (rst),
    .shift_en (key_shift),
    .digit    (key_data),
    .clear    (preset_clear),
    .preset   (load_data),
    .nonzero  (preset_nz)
  );

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx     = state;
    done_cnt_nx  = done_cnt;
    preset_clear = 1'b0;
    key_shift    = 1'b0;
    enablen      = 1'b1;

    case (state)
      S_IDLE: begin
        if (stop) begin
          preset_clear = 1'b1;
        end else if (start) begin
          if (!door_open && preset_nz) state_nx = S_LOAD;
        end else if (key_valid) begin
          key_shift = 1'b1;
        end
      end

      S_LOAD: state_nx = S_RUN;

      S_RUN: begin
        // Pause and expiry both win over the tick, so the chain never
        // decrements on the way out of RUN and never wraps below zero.
        if (door_open || stop) begin
          state_nx = S_PAUSE;
        end else if (timer_zero) begin
          state_nx    = S_DONE;
          done_cnt_nx = '0;
        end else if (tick) begin
          enablen = 1'b0;
        end
      end

      S_PAUSE: begin
        // An open door holds the pause regardless of the buttons.
        if (door_open) begin
          state_nx = S_PAUSE;
        end else if (stop) begin
          state_nx     = S_IDLE;
          preset_clear = 1'b1;
        end else if (start) begin
          state_nx = S_RUN;
        end
      end

      S_DONE: begin
        if (door_open || stop || start || key_valid) begin
          state_nx     = S_IDLE;
          preset_clear = stop;
        end else if (tick) begin
          if (done_cnt == LAST_TICK) begin
            state_nx     = S_IDLE;
            preset_clear = 1'b1;
          end else begin
            done_cnt_nx = done_cnt + 1'b1;
          end
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      done_cnt <= '0;
    end else begin
      state    <= state_nx;
      done_cnt <= done_cnt_nx;
    end
  end

  assign load    = (state == S_LOAD);
  assign heater  = (state == S_RUN);
  assign done    = (state == S_DONE);
  assign state_o = state;

endmodule

// File: tb/tb_timer_run_controller.sv
module tb_timer_run_controller;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        key_valid;
  logic [3:0]  key_data;
  logic        start;
  logic        stop;
  logic        door_open;
  logic        timer_zero;
  logic        load;
  logic [15:0] load_data;
  logic        enablen;
  logic        heater;
  logic        done;
  logic [2:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, PAUSE = 3'd3, DONE = 3'd4;

  timer_run_controller #(.DIGITS(4), .DONE_TICKS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .start      (start),
    .stop       (stop),
    .door_open  (door_open),
    .timer_zero (timer_zero),
    .load       (load),
    .load_data  (load_data),
    .enablen    (enablen),
    .heater     (heater),
    .done       (done),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        kv;
    logic [3:0]  kd;
    logic        st;
    logic        sp;
    logic        door;
    logic [2:0]  e_state;
    logic        e_load;
    logic        e_heater;
    logic [15:0] e_ld;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Step past the next rising edge and drop all one-cycle strobes.
  task automatic advance();
    @(posedge clk);
    #1;
    tick      = 1'b0;
    key_valid = 1'b0;
    key_data  = 4'd0;
    start     = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic ld,
                            input logic en, input logic ht, input logic dn);
    check({tag, ".state"},   16'(state_o), 16'(st));
    check({tag, ".load"},    16'(load),    16'(ld));
    check({tag, ".enablen"}, 16'(enablen), 16'(en));
    check({tag, ".heater"},  16'(heater),  16'(ht));
    check({tag, ".done"},    16'(done),    16'(dn));
  endtask

  initial begin
    int pulses;

    // {kv, kd, start, stop, door, state seen, load, heater, load_data seen}
    vecs[0]  = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 16'h0001};
    vecs[2]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 16'h0012};
    vecs[3]  = '{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 16'h0123};
    vecs[4]  = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 16'h1234};
    vecs[5]  = '{1'b1, 4'hA,  1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 16'h2345};
    vecs[6]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, IDLE, 1'b0, 1'b0, 16'h2345};
    vecs[7]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 16'h2345};
    vecs[8]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, IDLE, 1'b0, 1'b0, 16'h2345};
    vecs[9]  = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 16'h0001};
    vecs[11] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 16'h0013};
    vecs[12] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 16'h0130};
    vecs[13] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, LOAD, 1'b1, 1'b0, 16'h0130};
    vecs[14] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, RUN,  1'b0, 1'b1, 16'h0130};

    rst = 1'b0; tick = 1'b0; key_valid = 1'b0; key_data = 4'd0;
    start = 1'b0; stop = 1'b0; door_open = 1'b0; timer_zero = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    sample();
    check_outs("reset", IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
    check("reset.load_data", load_data, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;

    // Keypad entry, invalid digit, start with door open, stop clear, then start 0x0130
    for (int i = 0; i < 15; i++) begin
      key_valid = vecs[i].kv;
      key_data  = vecs[i].kd;
      start     = vecs[i].st;
      stop      = vecs[i].sp;
      door_open = vecs[i].door;
      sample();
      check($sformatf("vec%0d.state", i),     16'(state_o), 16'(vecs[i].e_state));
      check($sformatf("vec%0d.load", i),      16'(load),    16'(vecs[i].e_load));
      check($sformatf("vec%0d.heater", i),    16'(heater),  16'(vecs[i].e_heater));
      check($sformatf("vec%0d.enablen", i),   16'(enablen), 16'h0001);
      check($sformatf("vec%0d.load_data", i), load_data,    vecs[i].e_ld);
      advance();
      door_open = 1'b0;
    end

    // Tick every 4 cycles in RUN: enablen low exactly on tick cycles
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick = (i % 4 == 3);
      sample();
      check($sformatf("run%0d.enablen", i), 16'(enablen), 16'(!tick));
      if (!enablen) pulses++;
      advance();
    end
    check("run.pulses", 16'(pulses), 16'd5);
    sample();
    check_outs("run.after", RUN, 1'b0, 1'b1, 1'b1, 1'b0);
    advance();

    // Door opens on a tick cycle: no decrement, then PAUSE
    door_open = 1'b1; tick = 1'b1;
    sample();
    check_outs("door.tick", RUN, 1'b0, 1'b1, 1'b1, 1'b0);
    advance();
    sample();
    check_outs("pause", PAUSE, 1'b0, 1'b1, 1'b0, 1'b0);
    advance();
    door_open = 1'b0; tick = 1'b1;
    sample();
    check_outs("pause.tick", PAUSE, 1'b0, 1'b1, 1'b0, 1'b0);
    advance();
    start = 1'b1;
    sample();
    check_outs("pause.start", PAUSE, 1'b0, 1'b1, 1'b0, 1'b0);
    advance();
    sample();
    check_outs("resume", RUN, 1'b0, 1'b1, 1'b1, 1'b0);
    advance();

    // Expiry: timer_zero together with tick must not decrement
    timer_zero = 1'b1; tick = 1'b1;
    sample();
    check_outs("zero.tick", RUN, 1'b0, 1'b1, 1'b1, 1'b0);
    advance();
    for (int t = 1; t <= 3; t++) begin
      sample();
      check_outs($sformatf("done.wait%0d", t), DONE, 1'b0, 1'b1, 1'b0, 1'b1);
      advance();
      tick = 1'b1;
      sample();
      check_outs($sformatf("done.tick%0d", t), DONE, 1'b0, 1'b1, 1'b0, 1'b1);
      advance();
    end
    timer_zero = 1'b0;
    sample();
    check_outs("done.exit", IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
    check("done.exit.load_data", load_data, 16'h0000);
    advance();

    // Reset mid-RUN with a tick
    key_valid = 1'b1; key_data = 4'd5;
    advance();
    start = 1'b1;
    advance();
    advance();
    sample();
    check_outs("rst.pre", RUN, 1'b0, 1'b1, 1'b1, 1'b0);
    check("rst.pre.load_data", load_data, 16'h0005);
    rst = 1'b0; tick = 1'b1;
    advance();
    rst = 1'b1; tick = 1'b1;
    sample();
    check_outs("rst.post", IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rst.post.load_data", load_data, 16'h0000);
    advance();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
